// File: rtl/bram_req_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bram_req_sequencer_pkg
// Desc     : Sequencer FSM state encodings, counter width and saturating increment.
// Revision : 1.0
// ============================================================================
package bram_req_sequencer_pkg;

  localparam int PERF_CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR   = 3'd1;
  localparam state_t ST_RD   = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_RESP = 3'd4;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram_req_fifo
// Desc     : Request FIFO; registered count drives full/empty, head is shown combinationally.
// Revision : 1.0
// ============================================================================
module bram_req_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bram_req_sequencer
// Desc     : Buffers BRAM requests and replays them to bramctrlsimple; returns read data.
// Option   : BRAM_SEQ_PERF_CNT_EN adds saturating wr_count / rd_count outputs.
// Revision : 1.0
// ============================================================================
module bram_req_sequencer
  import bram_req_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  mem_access,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
`ifdef BRAM_SEQ_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] wr_count,
  output logic [PERF_CNT_W-1:0] rd_count,
`endif
  output logic                  idle
);

  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_mem_access_nxt;
  logic                  w_mem_req_nxt;
  logic                  w_rsp_capture;
  logic                  w_rsp_accept;

  bram_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .wdata ({req_we, req_addr, req_wdata}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head_we   = w_head[ENTRY_W-1];
  assign w_head_addr = w_head[ENTRY_W-2 -: ADDR_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  assign req_ready = !w_full;
  assign idle      = (r_state == ST_IDLE) && w_empty && !rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      mem_access  <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr_in <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      mem_access <= w_mem_access_nxt;
      mem_req    <= w_mem_req_nxt;
      // Address and write data only move when a request is issued; reads leave mem_data_in alone.
      if (w_pop) begin
        mem_addr_in <= w_head_addr;
        if (w_head_we) mem_data_in <= w_head_data;
      end
      if (r_state == ST_RD)        r_lat_cnt <= LAT_W'(READ_LATENCY);
      else if (r_state == ST_WAIT) r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      if (w_rsp_capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_data_out;
      end else if (w_rsp_accept) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE, ST_WR: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_we ? ST_WR : ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD:   w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_lat_cnt == LAT_W'(1)) w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head_we ? ST_WR : ST_RD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_access_nxt = (w_state_nxt == ST_WR) || (w_state_nxt == ST_RD);
    w_mem_req_nxt    = (w_state_nxt == ST_WR);
    w_rsp_capture    = (r_state == ST_WAIT) && (r_lat_cnt == LAT_W'(1));
    w_rsp_accept     = (r_state == ST_RESP) && rsp_ready;
  end

`ifdef BRAM_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (w_pop && w_head_we) wr_count <= sat_inc(wr_count);
      if (w_rsp_accept)       rd_count <= sat_inc(rd_count);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_req_sequencer.sv
`default_nettype none
// Bench for bram_req_sequencer: directed latency/backpressure/reset sequences, a vector table,
// and randomized traffic checked against an in-order shadow-memory scoreboard.
module tb_bram_req_sequencer;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic mem_access, mem_req;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic idle;
`ifdef BRAM_SEQ_PERF_CNT_EN
  logic [15:0] wr_count, rd_count;
`endif

  always #5 clk = ~clk;

  bram_req_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_access(mem_access), .mem_req(mem_req),
    .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
`ifdef BRAM_SEQ_PERF_CNT_EN
    .wr_count(wr_count), .rd_count(rd_count),
`endif
    .idle(idle)
  );

  // Single-port RAM behind the controller: write on mem_access&mem_req, read data RL cycles later.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] rd_pipe [RL];
  logic ram_clear;
  always @(posedge clk) begin
    if (ram_clear) for (int i = 0; i < 16; i++) ram[i] <= '0;
    else if (mem_access && mem_req) ram[mem_addr_in] <= mem_data_in;
    rd_pipe[0] <= ram[mem_addr_in];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[RL-1];

  int n_checks = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: requests take effect in acceptance order, so a read returns the shadow value at accept.
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rsp;
  logic [DW-1:0] exp_v;
  int rsp_seen = 0;
  int run = 0;
  int max_run = 0;
  logic b2b_mon = 1'b0, rdy_drop = 1'b0;
  logic stale_mon = 1'b0, stale = 1'b0;
  logic rand_rdy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) shadow[i] = ram[i];
    end else begin
      if (rsp_valid && rsp_ready) begin
        chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          chk("rsp_order_data", 32'(rsp_data), 32'(exp_v));
        end
        last_rsp = rsp_data;
        rsp_seen++;
      end
      if (req_valid && req_ready) begin
        if (req_we) shadow[req_addr] = req_wdata;
        else exp_q.push_back(shadow[req_addr]);
      end
      if (b2b_mon) begin
        if (mem_req) run++; else run = 0;
        if (run > max_run) max_run = run;
        if (!req_ready) rdy_drop = 1'b1;
      end
      if (stale_mon && rsp_valid) stale = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (idle && exp_q.size() == 0) ok = 1'b1;
    end
    chk("drain_done", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [9];

  int base;
  int bad;

  initial begin
    tbl[0] = '{1'b1, 4'h2, 4'h7, 4'h0};
    tbl[1] = '{1'b1, 4'h5, 4'h9, 4'h0};
    tbl[2] = '{1'b0, 4'h2, 4'h0, 4'h7};
    tbl[3] = '{1'b0, 4'h5, 4'h0, 4'h9};
    tbl[4] = '{1'b1, 4'h2, 4'h1, 4'h0};
    tbl[5] = '{1'b0, 4'h2, 4'h0, 4'h1};
    tbl[6] = '{1'b1, 4'hF, 4'hE, 4'h0};
    tbl[7] = '{1'b0, 4'hF, 4'h0, 4'hE};
    tbl[8] = '{1'b0, 4'h5, 4'h0, 4'h9};

    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1; ram_clear = 1; rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mem_access", 32'(mem_access), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_in), 32'd0);
    chk("rst_mem_data", 32'(mem_data_in), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1; ram_clear = 0;
    @(posedge clk); #1;

`ifdef BRAM_SEQ_PERF_CNT_EN
    send(1, 4'h0, 4'h1); send(1, 4'h1, 4'h2); send(1, 4'h2, 4'h3);
    send(0, 4'h0, 4'h0); send(0, 4'h1, 4'h0);
    wait_drain();
    chk("perf_wr_count", 32'(wr_count), 32'd3);
    chk("perf_rd_count", 32'(rd_count), 32'd2);
`endif

    // Write latency: accept edge 0, mem_req during cycle after edge 1, RAM updated at edge 2.
    send(1, 4'h3, 4'hA);
    @(negedge clk); chk("wr_lat_req_early", 32'(mem_req), 32'd0);
    @(negedge clk); chk("wr_lat_req", 32'(mem_req), 32'd1);
    chk("wr_lat_access", 32'(mem_access), 32'd1);
    chk("wr_lat_addr", 32'(mem_addr_in), 32'h3);
    chk("wr_lat_data", 32'(mem_data_in), 32'hA);
    @(negedge clk); chk("wr_ram_updated", 32'(ram[3]), 32'hA);
    @(posedge clk); #1;

    // Read latency: accept edge 0, rsp_valid after edge 3, single pulse.
    send(0, 4'h3, 4'h0);
    @(negedge clk); chk("rd_lat_access_early", 32'(mem_access), 32'd0);
    @(negedge clk); chk("rd_lat_access", 32'(mem_access), 32'd1);
    chk("rd_lat_req", 32'(mem_req), 32'd0);
    chk("rd_lat_addr", 32'(mem_addr_in), 32'h3);
    @(negedge clk); chk("rd_lat_valid_early", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("rd_lat_valid", 32'(rsp_valid), 32'd1);
    chk("rd_lat_data", 32'(rsp_data), 32'hA);
    @(negedge clk); chk("rd_pulse_end", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Back-to-back writes: one per cycle, req_ready never drops.
    max_run = 0; rdy_drop = 1'b0; b2b_mon = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 4'(i), 4'(i + 1));
    repeat (4) @(negedge clk);
    b2b_mon = 1'b0;
    chk("b2b_mem_req_run", 32'(max_run), 32'd4);
    chk("b2b_req_ready", 32'(rdy_drop), 32'd0);
    @(posedge clk); #1;

    // Backpressure: six reads with rsp_ready low.
    for (int a = 8; a < 14; a++) send(1, 4'(a), 4'(15 - a));
    wait_drain();
    base = rsp_seen;
    rsp_ready = 0;
    for (int a = 8; a < 13; a++) send(0, 4'(a), 4'h0);
    req_valid = 1; req_we = 0; req_addr = 4'hD; req_wdata = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      chk("bp_rsp_held", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_stable", 32'(rsp_data), 32'h7);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    send(0, 4'hD, 4'h0);
    wait_drain();
    chk("bp_rsp_count", 32'(rsp_seen - base), 32'd6);

    // Reset during WAIT discards the in-flight read.
    send(0, 4'h3, 4'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rst_wait_pre_valid", 32'(rsp_valid), 32'd0);
    #2 rst_n = 0;
    #1;
    chk("rst_wait_access", 32'(mem_access), 32'd0);
    chk("rst_wait_idle", 32'(idle), 32'd1);
    @(negedge clk);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    stale = 1'b0; stale_mon = 1'b1;
    repeat (10) @(negedge clk);
    stale_mon = 1'b0;
    chk("rst_no_stale_rsp", 32'(stale), 32'd0);
    chk("rst_idle_after", 32'(idle), 32'd1);
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      base = rsp_seen;
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (!tbl[i].we) begin
        for (int n = 0; n < 50 && rsp_seen == base; n++) @(negedge clk);
        chk("tbl_rsp_seen", 32'(rsp_seen - base), 32'd1);
        chk($sformatf("tbl_rdata[%0d]", i), 32'(last_rsp), 32'(tbl[i].exp));
        @(posedge clk); #1;
      end
    end
    wait_drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    rand_rdy = 1'b0;
    rsp_ready = 1;
    wait_drain();
    bad = 0;
    for (int a = 0; a < 16; a++) if (ram[a] !== shadow[a]) bad++;
    chk("final_ram_matches_model", 32'(bad), 32'd0);
    chk("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
